// File: rtl/polar_pkg.sv
`default_nettype none
// ============================================================================
// Package : polar_pkg
// Brief   : Shared types and default sizes for the polar encoder/decoder pair.
//           The frozen-RAM address width is common to the encoder core and
//           the SC decoder controller, which read the same RAM image.
// Rev     : 1.0 - initial release
// ============================================================================
package polar_pkg;

  localparam int DEF_CODE_LENGTH       = 1024;
  localparam int DEF_COUNTER_WIDTH     = 10;
  localparam int FROZEN_RAM_ADDR_WIDTH = DEF_COUNTER_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    DECIDE = 3'd2,
    ENCODE = 3'd3,
    OUTPUT = 3'd4
  } enc_state_e;

endpackage
`default_nettype wire

// File: rtl/polar_butterfly_stage.sv
`default_nettype none
// ============================================================================
// Module : polar_butterfly_stage
// Brief  : One XOR stage of x = u * F^(xn), natural order. For every index i
//          whose bit s is clear, i takes u[i] ^ u[i + 2^s]; other bits pass.
//          All stages are built and the requested one is selected.
// Rev    : 1.0 - initial release
// ============================================================================
module polar_butterfly_stage
  import polar_pkg::*;
#(
  parameter int CODE_LENGTH   = DEF_CODE_LENGTH,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
  input  logic [CODE_LENGTH-1:0]   u_in,
  input  logic [COUNTER_WIDTH-1:0] stage,
  output logic [CODE_LENGTH-1:0]   u_out
);

  logic [CODE_LENGTH-1:0] stage_res [COUNTER_WIDTH];

  for (genvar s = 0; s < COUNTER_WIDTH; s++) begin : g_stage
    for (genvar i = 0; i < CODE_LENGTH; i++) begin : g_bit
      if (((i >> s) & 1) == 0) begin : g_upper
        assign stage_res[s][i] = u_in[i] ^ u_in[i + (1 << s)];
      end else begin : g_lower
        assign stage_res[s][i] = u_in[i];
      end
    end
  end

  // Select the butterfly result for the current stage index.
  always_comb begin
    u_out = u_in;
    for (int s = 0; s < COUNTER_WIDTH; s++) begin
      if (stage == COUNTER_WIDTH'(s)) begin
        u_out = stage_res[s];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/polar_encoder_core.sv
`default_nettype none
// ============================================================================
// Module : polar_encoder_core
// Brief  : Builds an N-bit frame u from info bits and the frozen-bit RAM,
//          encodes it in place with one butterfly stage per cycle and streams
//          x out serially with a valid/ready handshake.
// Rev    : 1.0 - initial release
// ============================================================================
module polar_encoder_core
  import polar_pkg::*;
#(
  parameter int CODE_LENGTH                          = DEF_CODE_LENGTH,
  parameter int COUNTER_WIDTH                        = DEF_COUNTER_WIDTH,
  parameter int FROZEN_BIT_INDICATION_RAM_ADDR_WIDTH = FROZEN_RAM_ADDR_WIDTH
) (
  input  logic                                            clk,
  input  logic                                            reset_n,
  input  logic                                            start,
  input  logic                                            info_bit,
  input  logic                                            info_valid,
  output logic                                            info_ready,
  output logic [FROZEN_BIT_INDICATION_RAM_ADDR_WIDTH-1:0] frozen_bit_indication_ram_rd_addr,
  input  logic                                            frozen_bit_indication_ram_rd_data,
  output logic                                            code_bit,
  output logic                                            code_valid,
  input  logic                                            code_ready,
  output logic                                            busy,
  output logic                                            frame_done
);

  enc_state_e               state, state_next;
  logic [COUNTER_WIDTH-1:0] idx;
  logic [COUNTER_WIDTH-1:0] stage;
  logic [CODE_LENGTH-1:0]   u_reg;
  logic [CODE_LENGTH-1:0]   u_next;
  logic                     idx_last;
  logic                     stage_last;
  logic                     fill_step;
  logic                     out_step;

  assign idx_last   = (idx == COUNTER_WIDTH'(CODE_LENGTH - 1));
  assign stage_last = (stage == COUNTER_WIDTH'(COUNTER_WIDTH - 1));

  // The RAM address is the position counter itself, so it moves only with idx.
  assign frozen_bit_indication_ram_rd_addr = FROZEN_BIT_INDICATION_RAM_ADDR_WIDTH'(idx);

  polar_butterfly_stage #(
    .CODE_LENGTH  (CODE_LENGTH),
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_butterfly (
    .u_in (u_reg),
    .stage(stage),
    .u_out(u_next)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs; outputs decode the current state
  // so they fall to their idle values as soon as reset clears the state.
  always_comb begin
    state_next = state;
    info_ready = 1'b0;
    code_valid = 1'b0;
    code_bit   = 1'b0;
    frame_done = 1'b0;
    fill_step  = 1'b0;
    out_step   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        state_next = DECIDE;
      end
      DECIDE: begin
        if (frozen_bit_indication_ram_rd_data) begin
          fill_step = 1'b1;
        end else begin
          info_ready = 1'b1;
          fill_step  = info_valid;
        end
        if (fill_step) begin
          state_next = idx_last ? ENCODE : LOOKUP;
        end
      end
      ENCODE: begin
        if (stage_last) begin
          state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        code_valid = 1'b1;
        code_bit   = u_reg[idx];
        out_step   = code_ready;
        if (code_ready && idx_last) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Position counter, stage counter and frame register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= '0;
      stage <= '0;
      u_reg <= '0;
    end else begin
      if (fill_step) begin
        u_reg[idx] <= frozen_bit_indication_ram_rd_data ? 1'b0 : info_bit;
        idx        <= idx_last ? '0 : idx + 1'b1;
      end
      if (state == ENCODE) begin
        u_reg <= u_next;
        stage <= stage_last ? '0 : stage + 1'b1;
      end
      if (out_step) begin
        idx <= idx_last ? '0 : idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_polar_encoder_core.sv
`default_nettype none
// ============================================================================
// Module : tb_polar_encoder_core
// Brief  : Self-checking bench for polar_encoder_core with N=8. Expected code
//          words come from hand-derived table entries and from a reference
//          model computing x[j] = XOR of u[i] over all i whose bits cover j.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_polar_encoder_core;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         info_bit;
  logic         info_valid;
  logic         info_ready;
  logic [W-1:0] rd_addr;
  logic         rd_data;
  logic         code_bit;
  logic         code_valid;
  logic         code_ready;
  logic         busy;
  logic         frame_done;

  logic [N-1:0] frozen_mask;

  int checks = 0;
  int passes = 0;

  polar_encoder_core #(
    .CODE_LENGTH                         (N),
    .COUNTER_WIDTH                       (W),
    .FROZEN_BIT_INDICATION_RAM_ADDR_WIDTH(W)
  ) dut (
    .clk                              (clk),
    .reset_n                          (reset_n),
    .start                            (start),
    .info_bit                         (info_bit),
    .info_valid                       (info_valid),
    .info_ready                       (info_ready),
    .frozen_bit_indication_ram_rd_addr(rd_addr),
    .frozen_bit_indication_ram_rd_data(rd_data),
    .code_bit                         (code_bit),
    .code_valid                       (code_valid),
    .code_ready                       (code_ready),
    .busy                             (busy),
    .frame_done                       (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frozen-bit RAM with one cycle of read latency.
  always @(posedge clk) rd_data <= frozen_mask[rd_addr];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference: place info bits in unfrozen positions in order, then
  // x[j] is the parity of u over every index i that contains all bits of j.
  function automatic logic [N-1:0] ref_encode(input logic [N-1:0] mask, input logic [N-1:0] info);
    logic [N-1:0] u;
    logic [N-1:0] x;
    int k;
    k = 0;
    u = '0;
    for (int i = 0; i < N; i++) begin
      if (!mask[i]) begin
        u[i] = info[k];
        k++;
      end
    end
    x = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        if ((i & j) == j) x[j] = x[j] ^ u[i];
    return x;
  endfunction

  task automatic run_frame(input logic [N-1:0] mask, input logic [N-1:0] info,
                           input bit rand_valid, input int stall_k, input bit spam,
                           output logic [N-1:0] got_x, output int busy_cyc,
                           output int consumed, output int done_cnt, output int viol,
                           output int unstable, output bit timed_out);
    int  out_k;
    int  stall_cnt;
    bit  prev_hold;
    logic prev_bit;
    got_x = '0; busy_cyc = 0; consumed = 0; done_cnt = 0; viol = 0; unstable = 0;
    timed_out = 1'b1; out_k = 0; stall_cnt = 0; prev_hold = 1'b0; prev_bit = 1'b0;
    frozen_mask = mask;
    @(negedge clk);
    start = 1'b1; info_valid = 1'b0; code_ready = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      start      = spam && busy;
      info_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      info_bit   = (consumed < N) ? info[consumed] : 1'($urandom_range(0, 1));
      code_ready = !(out_k == stall_k && stall_cnt < 5);
      #1;
      if (busy) busy_cyc++;
      if (info_ready && frozen_mask[rd_addr]) viol++;
      if (info_ready && info_valid) consumed++;
      if (prev_hold && !(code_valid && code_bit == prev_bit)) unstable++;
      prev_hold = code_valid && !code_ready;
      prev_bit  = code_bit;
      if (code_valid && !code_ready) stall_cnt++;
      if (code_valid && code_ready && out_k < N) begin
        got_x[out_k] = code_bit;
        out_k++;
      end
      if (frame_done) begin
        done_cnt++;
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0; info_valid = 1'b0; code_ready = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0] info;
    logic [N-1:0] exp_x;
    int           exp_info;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [N-1:0] got_x;
    logic [N-1:0] mask;
    logic [N-1:0] info;
    int busy_cyc, consumed, done_cnt, viol, unstable;
    bit timed_out;
    bit found;

    // x bit k is x[k]; info bit k is the k-th info bit consumed.
    vecs[0] = '{mask: 8'h00, info: 8'h01, exp_x: 8'h01, exp_info: 8};
    vecs[1] = '{mask: 8'h00, info: 8'h80, exp_x: 8'hFF, exp_info: 8};
    vecs[2] = '{mask: 8'h17, info: 8'h01, exp_x: 8'h0F, exp_info: 4};
    vecs[3] = '{mask: 8'hFF, info: 8'h00, exp_x: 8'h00, exp_info: 0};
    vecs[4] = '{mask: 8'h00, info: 8'hFF, exp_x: 8'h80, exp_info: 8};
    vecs[5] = '{mask: 8'h17, info: 8'h0F, exp_x: 8'h96, exp_info: 4};

    reset_n = 1'b0; start = 1'b0; info_bit = 1'b0; info_valid = 1'b0;
    code_ready = 1'b1; frozen_mask = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_info_ready", info_ready, 0);
    check("rst_code_valid", code_valid, 0);
    check("rst_code_bit", code_bit, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_rd_addr", rd_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table: always-valid info, full-rate output.
    foreach (vecs[v]) begin
      run_frame(vecs[v].mask, vecs[v].info, 1'b0, -1, 1'b0,
                got_x, busy_cyc, consumed, done_cnt, viol, unstable, timed_out);
      check($sformatf("tbl%0d_timeout", v), timed_out, 0);
      check($sformatf("tbl%0d_x", v), got_x, vecs[v].exp_x);
      check($sformatf("tbl%0d_consumed", v), consumed, vecs[v].exp_info);
      check($sformatf("tbl%0d_done", v), done_cnt, 1);
      check($sformatf("tbl%0d_ready_frozen", v), viol, 0);
      // fill 2*N + encode log2N + output N
      check($sformatf("tbl%0d_busy_cycles", v), busy_cyc, 2 * N + W + N);
    end

    // Output back-pressure: code_ready low for 5 cycles at k=3.
    run_frame(8'h17, 8'h0F, 1'b0, 3, 1'b0,
              got_x, busy_cyc, consumed, done_cnt, viol, unstable, timed_out);
    check("stall_timeout", timed_out, 0);
    check("stall_x", got_x, ref_encode(8'h17, 8'h0F));
    check("stall_stable", unstable, 0);
    check("stall_busy_cycles", busy_cyc, 2 * N + W + N + 5);

    // start asserted throughout the busy period is ignored.
    run_frame(8'h00, 8'h5A, 1'b0, -1, 1'b1,
              got_x, busy_cyc, consumed, done_cnt, viol, unstable, timed_out);
    check("spam_x", got_x, ref_encode(8'h00, 8'h5A));
    check("spam_done", done_cnt, 1);
    check("spam_busy_cycles", busy_cyc, 2 * N + W + N);
    @(negedge clk);
    #1;
    check("spam_idle_after", busy, 0);

    // Random frames: frozen {0,1,2,4}, random info_valid.
    for (int f = 0; f < 100; f++) begin
      info = N'($urandom);
      run_frame(8'h17, info, 1'b1, -1, 1'b0,
                got_x, busy_cyc, consumed, done_cnt, viol, unstable, timed_out);
      check($sformatf("rnd%0d_x", f), got_x, ref_encode(8'h17, info));
      check($sformatf("rnd%0d_consumed", f), consumed, 4);
      check($sformatf("rnd%0d_ready_frozen", f), viol, 0);
      check($sformatf("rnd%0d_done", f), done_cnt, 1);
    end

    // Random masks as well.
    for (int f = 0; f < 20; f++) begin
      mask = N'($urandom);
      info = N'($urandom);
      run_frame(mask, info, 1'b1, (f % 4 == 0) ? int'($urandom_range(0, N - 1)) : -1, 1'b0,
                got_x, busy_cyc, consumed, done_cnt, viol, unstable, timed_out);
      check($sformatf("rmask%0d_x", f), got_x, ref_encode(mask, info));
      check($sformatf("rmask%0d_consumed", f), consumed, N - $countones(mask));
      check($sformatf("rmask%0d_stable", f), unstable, 0);
    end

    // Reset while waiting in DECIDE at idx 5.
    frozen_mask = 8'h00;
    @(negedge clk);
    start = 1'b1; info_valid = 1'b0; info_bit = 1'b1;
    found = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      info_valid = (rd_addr < 5) ? 1'b1 : 1'b0;
      #1;
      if (info_ready && rd_addr == 5) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst_reached", found, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_info_ready", info_ready, 0);
    check("midrst_code_valid", code_valid, 0);
    check("midrst_rd_addr", rd_addr, 0);
    check("midrst_frame_done", frame_done, 0);
    info_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_frame(8'h00, 8'h01, 1'b0, -1, 1'b0,
              got_x, busy_cyc, consumed, done_cnt, viol, unstable, timed_out);
    check("postrst_x", got_x, 8'h01);
    check("postrst_done", done_cnt, 1);
    check("postrst_busy_cycles", busy_cyc, 2 * N + W + N);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
